store_buffer: RTL and testbench

Posted-write buffer between the single-cycle core's data-memory outputs (ALU address, write data, memory-write strobe) and a slower handshaked data memory. It accepts each store in one cycle so the core does not wait on memory, drains stores in order to memory, and forwards buffered data to loads so the core's read data is always coherent. When full, it raises a stall that freezes the core's PC register and register-file write.

---
 rtl/store_buffer.sv | 151 +++++++++++++++
 tb/tb_store_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with in-order drain and load forwarding
//
// Accepts one core store per cycle into a circular FIFO, drains the oldest
// entry to a handshaked data memory, and forwards the youngest matching
// buffered store to core loads so read data is always coherent.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   memwrite   core store strobe
//   memtoreg   core load indicator
//   aluout     byte address from core (bits [1:0] ignored)
//   writedata  store data from core
//   readdata   load data to core (combinational)
//   stall      core must hold the current instruction
//   count      number of valid entries
//   mem_req    head write request to memory
//   mem_addr   head entry word-aligned address
//   mem_wdata  head entry data
//   mem_ack    memory accepted the head write at this edge
//   mem_raddr  asynchronous read address to memory
//   mem_rdata  asynchronous read data from memory
//
// Optional feature macro: STORE_BUF_COALESCE_EN
//   When defined, a store hitting a valid non-head entry overwrites that
//   entry's data in place instead of allocating.

module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         memwrite,
   input  logic                         memtoreg,
   input  logic [31:0]                  aluout,
   input  logic [31:0]                  writedata,
   output logic [31:0]                  readdata,
   output logic                         stall,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         mem_req,
   output logic [31:0]                  mem_addr,
   output logic [31:0]                  mem_wdata,
   input  logic                         mem_ack,
   output logic [31:0]                  mem_raddr,
   input  logic [31:0]                  mem_rdata
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [29:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [CW-1:0] count_q;

   logic          full;
   logic          enq;
   logic          deq;
   logic          coalesce_hit;
   logic          fwd_hit;
   logic [31:0]   fwd_data;
   logic          unused_lsbs;

   // Word access only; the byte offset is intentionally dropped.
   assign unused_lsbs = ^aluout[1:0];

   assign count     = count_q;
   assign full      = (count_q == CW'(DEPTH));
   assign mem_req   = (count_q != '0);
   // Gate head fields so the outputs read zero while the buffer is empty.
   assign mem_addr  = mem_req ? {addr_q[head_q], 2'b00} : 32'h0;
   assign mem_wdata = mem_req ? data_q[head_q] : 32'h0;
   assign mem_raddr = {aluout[31:2], 2'b00};

   assign deq   = mem_req && mem_ack;
   // Stall looks at the count at the start of the cycle only; an ack in the
   // same cycle does not open a slot for this store.
   assign stall = memwrite && full && !coalesce_hit;
   assign enq   = memwrite && !stall && !coalesce_hit;

   // Walk valid entries oldest to youngest so the last match is the youngest.
   // The head still forwards while it is being acked this cycle.
   always_comb begin : forward
      fwd_hit  = 1'b0;
      fwd_data = 32'h0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < count_q) && (addr_q[head_q + PW'(k)] == aluout[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[head_q + PW'(k)];
         end
      end
   end

   assign readdata = (memtoreg && fwd_hit) ? fwd_data : mem_rdata;

`ifdef STORE_BUF_COALESCE_EN
   logic [PW-1:0] coalesce_idx;

   // Search starts at age 1: the head may already be in flight to memory,
   // so it must never be modified.
   always_comb begin : coalesce
      coalesce_hit = 1'b0;
      coalesce_idx = '0;
      if (memwrite) begin
         for (int k = 1; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && (addr_q[head_q + PW'(k)] == aluout[31:2])) begin
               coalesce_hit = 1'b1;
               coalesce_idx = head_q + PW'(k);
            end
         end
      end
   end
`else
   assign coalesce_hit = 1'b0;
`endif

   // Entry storage needs no reset; validity is derived from head and count.
   always_ff @(posedge clk) begin : storage
      if (reset && enq) begin
         addr_q[tail_q] <= aluout[31:2];
         data_q[tail_q] <= writedata;
      end
`ifdef STORE_BUF_COALESCE_EN
      if (reset && coalesce_hit) begin
         data_q[coalesce_idx] <= writedata;
      end
`endif
   end

   always_ff @(posedge clk) begin : pointers
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (enq) begin
            tail_q <= tail_q + PW'(1);
         end
         if (deq) begin
            head_q <= head_q + PW'(1);
         end
         case ({enq, deq})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized and directed self-checking bench for store_buffer

module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          reset;
   logic          memwrite;
   logic          memtoreg;
   logic [31:0]   aluout;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          stall;
   logic [CW-1:0] count;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ack;
   logic [31:0]   mem_raddr;
   logic [31:0]   mem_rdata;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .memtoreg  (memtoreg),
      .aluout    (aluout),
      .writedata (writedata),
      .readdata  (readdata),
      .stall     (stall),
      .count     (count),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [29:0] a;
      logic [31:0] d;
   } ent_t;

   // Reference: queue of pending stores, oldest at index 0.
   ent_t        q[$];
   logic [31:0] log_a[$];
   logic [31:0] log_d[$];

   int          total = 0;
   int          bad   = 0;
   int          hit_j;
   logic        exp_stall;
   logic [31:0] exp_rd;
   logic        s_req;
   logic [31:0] s_addr;
   logic [31:0] s_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Apply inputs just after the falling edge and evaluate the reference.
   task automatic drive(input logic r, input logic mw, input logic mr,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic [31:0] rd, input logic ack);
      reset     = r;
      memwrite  = mw;
      memtoreg  = mr;
      aluout    = ad;
      writedata = wd;
      mem_rdata = rd;
      mem_ack   = ack;
      #1;
      hit_j = -1;
`ifdef STORE_BUF_COALESCE_EN
      if (mw) begin
         for (int i = 1; i < q.size(); i++) begin
            if (q[i].a == ad[31:2]) hit_j = i;
         end
      end
`endif
      exp_stall = mw && (q.size() == DEPTH) && (hit_j < 0);
      exp_rd = rd;
      if (mr) begin
         for (int i = 0; i < q.size(); i++) begin
            if (q[i].a == ad[31:2]) exp_rd = q[i].d;
         end
      end
      s_req  = mem_req;
      s_addr = mem_addr;
      s_data = mem_wdata;
   endtask

   task automatic check_model();
      logic [31:0] ea;
      logic [31:0] ed;
      ea = (q.size() != 0) ? {q[0].a, 2'b00} : 32'h0;
      ed = (q.size() != 0) ? q[0].d : 32'h0;
      chk("count",     32'(count),   32'(q.size()));
      chk("mem_req",   32'(mem_req), 32'(q.size() != 0));
      chk("mem_addr",  mem_addr,     ea);
      chk("mem_wdata", mem_wdata,    ed);
      chk("stall",     32'(stall),   32'(exp_stall));
      chk("readdata",  readdata,     exp_rd);
      chk("mem_raddr", mem_raddr,    {aluout[31:2], 2'b00});
   endtask

   task automatic edge_update();
      ent_t e;
      logic deq;
      @(posedge clk);
      if (!reset) begin
         q.delete();
      end else begin
         deq = (q.size() != 0) && mem_ack;
         if (s_req && mem_ack) begin
            log_a.push_back(s_addr);
            log_d.push_back(s_data);
         end
         if (hit_j >= 0) begin
            q[hit_j].d = writedata;
         end else if (memwrite && !exp_stall) begin
            e.a = aluout[31:2];
            e.d = writedata;
            q.push_back(e);
         end
         if (deq) void'(q.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic step(input logic r, input logic mw, input logic mr,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] rd, input logic ack);
      drive(r, mw, mr, ad, wd, rd, ack);
      check_model();
      edge_update();
   endtask

   task automatic fill4();
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'(32'hA0 + i), 32'h0, 1'b0);
      end
   endtask

   initial begin
      reset = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; aluout = 32'h0;
      writedata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      drive(1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h1234_5678, 1'b0);
      chk("rst_count",     32'(count),   32'h0);
      chk("rst_mem_req",   32'(mem_req), 32'h0);
      chk("rst_stall",     32'(stall),   32'h0);
      chk("rst_mem_addr",  mem_addr,     32'h0);
      chk("rst_mem_wdata", mem_wdata,    32'h0);
      chk("rst_readdata",  readdata,     32'h1234_5678);
      chk("rst_mem_raddr", mem_raddr,    32'h0000_0200);
      check_model();
      edge_update();

      // Single store, latency and forwarding
      step(1'b1, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0);
      chk("st_count",     32'(count),   32'h1);
      chk("st_mem_req",   32'(mem_req), 32'h1);
      chk("st_mem_addr",  mem_addr,     32'h100);
      chk("st_mem_wdata", mem_wdata,    32'hDEAD_BEEF);
      drive(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 32'h0, 1'b0);
      chk("st_fwd", readdata, 32'hDEAD_BEEF);
      check_model();
      edge_update();

      // Full buffer stall and release
      fill4();
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h5, 32'h0, 1'b0);
      chk("full_stall", 32'(stall), 32'h1);
      check_model();
      edge_update();
      chk("full_count", 32'(count), 32'h4);
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h5, 32'h0, 1'b1);
      chk("ack_cycle_stall", 32'(stall), 32'h1);
      check_model();
      edge_update();
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h5, 32'h0, 1'b0);
      chk("release_stall", 32'(stall), 32'h0);
      check_model();
      edge_update();
      chk("release_count", 32'(count), 32'h4);
      chk("release_head",  mem_addr,   32'h4);

      // In-order drain at one entry per cycle
      fill4();
      log_a.delete(); log_d.delete();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      chk("drain_count", 32'(count), 32'h0);
      chk("drain_n", 32'(log_a.size()), 32'h4);
      if (log_a.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("drain_addr", log_a[i], 32'(i * 4));
      end

      // Youngest-match forwarding, and fall-through to memory
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 32'h40, 32'h11, 32'h0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 32'h40, 32'h22, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 1'b0);
      chk("fwd_young", readdata, 32'h22);
      check_model();
      edge_update();
      drive(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 32'h55, 1'b0);
      chk("fwd_miss", readdata, 32'h55);
      check_model();
      edge_update();

      // Reset with pending entries
      step(1'b1, 1'b1, 1'b0, 32'h44, 32'h33, 32'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      chk("rst2_count",   32'(count),   32'h0);
      chk("rst2_mem_req", 32'(mem_req), 32'h0);
      log_a.delete(); log_d.delete();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      chk("rst2_no_writes", 32'(log_a.size()), 32'h0);

`ifdef STORE_BUF_COALESCE_EN
      // Coalesce into a full buffer
      fill4();
      drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h99, 32'h0, 1'b0);
      chk("coal_stall", 32'(stall), 32'h0);
      check_model();
      edge_update();
      chk("coal_count", 32'(count), 32'h4);
      log_a.delete(); log_d.delete();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      chk("coal_n", 32'(log_a.size()), 32'h4);
      if (log_a.size() == 4) begin
         chk("coal_addr", log_a[2], 32'h8);
         chk("coal_data", log_d[2], 32'h99);
      end
`endif

      // Randomized traffic over a small address window to force hits
      for (int n = 0; n < 2000; n++) begin
         logic        r;
         logic        mw;
         logic        mr;
         logic [31:0] ad;
         r  = ($urandom_range(0, 99) != 0);
         mw = ($urandom_range(0, 1) == 1);
         mr = ($urandom_range(0, 2) == 0);
         ad = (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
         step(r, mw, mr, ad, $urandom, $urandom, ($urandom_range(0, 2) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
